// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: word/address widths,
// reset vector default and fetch FSM state encodings.
package instruction_fetch_unit_pkg;

  localparam int          IFU_DATA_LENGTH    = 16;
  localparam int          IFU_ADDRESS_LENGTH = 16;
  localparam int unsigned IFU_RESET_VECTOR   = 32'h0;

  typedef enum logic [1:0] {
    IFU_REQ    = 2'd0,
    IFU_HOLD   = 2'd1,
    IFU_HALTED = 2'd2
  } ifu_state_e;

endpackage

// File: rtl/instruction_fetch_unit_prefetch_fifo.sv
// Two-entry FIFO holding {pc, word} pairs between instruction RAM and the
// decoder. Only built when IFU_PREFETCH_EN is defined, since nothing else
// instantiates it. Caller never pushes into a full FIFO unless it also pops.
`ifdef IFU_PREFETCH_EN
module ifu_prefetch_fifo #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [1:0]       count,
  output logic             empty
);

  logic [1:0][WIDTH-1:0] mem_q, mem_d;
  logic                  rd_q, rd_d, wr_q, wr_d;
  logic [1:0]            cnt_q, cnt_d;
  logic                  do_pop;

  // Pointer/count update; flush wins over push and pop in the same cycle.
  always_comb begin
    mem_d  = mem_q;
    rd_d   = rd_q;
    wr_d   = wr_q;
    cnt_d  = cnt_q;
    do_pop = pop & (cnt_q != 2'd0);
    if (flush) begin
      rd_d  = 1'b0;
      wr_d  = 1'b0;
      cnt_d = 2'd0;
    end else begin
      if (push) begin
        mem_d[wr_q] = wdata;
        wr_d        = ~wr_q;
      end
      if (do_pop) rd_d = ~rd_q;
      cnt_d = cnt_q + {1'b0, push} - {1'b0, do_pop};
    end
  end

  // Storage and pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '0;
      rd_q  <= 1'b0;
      wr_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      mem_q <= mem_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  assign rdata = mem_q[rd_q];
  assign count = cnt_q;
  assign empty = (cnt_q == 2'd0);

endmodule
`endif

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues req/ack reads to instruction
// RAM and offers fetched words to the decoder over valid/ready. Handles
// redirects (jumps) and halt requests from execute.
// IFU_PREFETCH_EN defined: 2-entry prefetch FIFO, up to 1 instr/cycle.
// Undefined: single holding register, REQ/HOLD/HALTED FSM, 1 instr/2 cycles.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int          dataLength    = IFU_DATA_LENGTH,
  parameter int          addressLength = IFU_ADDRESS_LENGTH,
  parameter int unsigned resetVector   = IFU_RESET_VECTOR
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [addressLength-1:0] mem_addr,
  output logic                     mem_rd,
  input  logic                     mem_ack,
  input  logic [dataLength-1:0]    mem_data,
  output logic [dataLength-1:0]    instr_out,
  output logic [addressLength-1:0] instr_pc,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  input  logic                     redirect,
  input  logic [addressLength-1:0] redirect_addr,
  input  logic                     halt,
  output logic                     halted
);

  ifu_state_e               state_q, state_d;
  logic [addressLength-1:0] pc_q, pc_d;
  logic                     mem_rd_q, mem_rd_d;

`ifdef IFU_PREFETCH_EN
  localparam int W = dataLength + addressLength;

  logic         push, pop, flush, f_empty;
  logic [1:0]   f_count;
  logic [W-1:0] f_head;

  ifu_prefetch_fifo #(.WIDTH(W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata ({pc_q, mem_data}),
    .rdata (f_head),
    .count (f_count),
    .empty (f_empty)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IFU_REQ;
      pc_q     <= addressLength'(resetVector);
      mem_rd_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      mem_rd_q <= mem_rd_d;
    end
  end

  // Next state: keep requesting while the FIFO has room after this cycle.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    mem_rd_d = 1'b0;
    push     = 1'b0;
    flush    = 1'b0;
    pop      = ~f_empty & instr_ready;
    if (redirect) begin
      flush   = 1'b1;
      pc_d    = redirect_addr;
      state_d = IFU_REQ;
    end else if (state_q == IFU_REQ) begin
      if (halt) begin
        state_d = IFU_HALTED;
      end else begin
        push = mem_rd_q & mem_ack;
        if (push) pc_d = pc_q + addressLength'(1);
        mem_rd_d = !((f_count == 2'd2 && !pop) ||
                     (f_count == 2'd1 && push && !pop));
      end
    end
  end

  // Outputs: decoder sees the FIFO head; halted once queued work drained.
  always_comb begin
    mem_rd                = mem_rd_q;
    mem_addr              = pc_q;
    instr_valid           = ~f_empty;
    {instr_pc, instr_out} = f_head;
    halted                = (state_q == IFU_HALTED) && f_empty;
  end

`else
  logic [dataLength-1:0]    instr_q, instr_d;
  logic [addressLength-1:0] ipc_q, ipc_d;
  logic                     valid_q, valid_d, halted_q, halted_d;
  logic                     take, xfer;

  // An ack only counts while our request is actually on the bus.
  assign take = mem_rd_q & mem_ack;
  assign xfer = valid_q & instr_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IFU_REQ;
      pc_q     <= addressLength'(resetVector);
      mem_rd_q <= 1'b0;
      instr_q  <= '0;
      ipc_q    <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      mem_rd_q <= mem_rd_d;
      instr_q  <= instr_d;
      ipc_q    <= ipc_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
    end
  end

  // Next state: redirect > halt > ack/transfer.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    mem_rd_d = mem_rd_q;
    instr_d  = instr_q;
    ipc_d    = ipc_q;
    valid_d  = valid_q;
    halted_d = halted_q;
    if (redirect) begin
      // Flush; any ack this cycle is dropped and the bus idles one cycle.
      state_d  = IFU_REQ;
      pc_d     = redirect_addr;
      mem_rd_d = 1'b0;
      valid_d  = 1'b0;
      halted_d = 1'b0;
    end else begin
      case (state_q)
        IFU_REQ: begin
          if (halt) begin
            state_d  = IFU_HALTED;
            mem_rd_d = 1'b0;
            halted_d = 1'b1;
          end else if (take) begin
            instr_d  = mem_data;
            ipc_d    = pc_q;
            pc_d     = pc_q + addressLength'(1);
            valid_d  = 1'b1;
            mem_rd_d = 1'b0;
            state_d  = IFU_HOLD;
          end else begin
            mem_rd_d = 1'b1;
          end
        end
        IFU_HOLD: begin
          // Halt is honoured at the instruction boundary, i.e. on transfer.
          if (xfer) begin
            valid_d = 1'b0;
            if (halt) begin
              state_d  = IFU_HALTED;
              halted_d = 1'b1;
            end else begin
              state_d  = IFU_REQ;
              mem_rd_d = 1'b1;
            end
          end
        end
        IFU_HALTED: ;
        default: state_d = IFU_REQ;
      endcase
    end
  end

  // Outputs straight from the registers.
  always_comb begin
    mem_rd      = mem_rd_q;
    mem_addr    = pc_q;
    instr_out   = instr_q;
    instr_pc    = ipc_q;
    instr_valid = valid_q;
    halted      = halted_q;
  end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit (default build, no prefetch).
// Directed scenarios followed by a randomized run scored against an
// address-sequence model of the fetch stream.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic        mem_ack;
  logic [15:0] mem_data;
  logic [15:0] instr_out;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [15:0] redirect_addr;
  logic        halt;
  logic        halted;

  int n_checks = 0;
  int n_fail   = 0;

  instruction_fetch_unit dut (
    .clk           (clk),
    .rst           (rst),
    .mem_addr      (mem_addr),
    .mem_rd        (mem_rd),
    .mem_ack       (mem_ack),
    .mem_data      (mem_data),
    .instr_out     (instr_out),
    .instr_pc      (instr_pc),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .halt          (halt),
    .halted        (halted)
  );

  always #5 clk = ~clk;

  // Contents of the modelled instruction RAM.
  function automatic logic [15:0] ram_word(input logic [15:0] a);
    logic [15:0] p;
    p = a * 16'h9E37;
    return p ^ 16'h5A5A;
  endfunction

  // One rising edge; return at the following falling edge (sample/drive point).
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_ack = 1'b0; mem_data = '0; instr_ready = 1'b0;
    redirect = 1'b0; redirect_addr = '0; halt = 1'b0;
    @(negedge clk);
    step();
    n_checks++; if (mem_rd !== 1'b0) begin n_fail++; $display("FAIL rst_mem_rd got=%b exp=0", mem_rd); end
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got=%b exp=0", instr_valid); end
    n_checks++; if (instr_out !== 16'h0) begin n_fail++; $display("FAIL rst_instr_out got=%h exp=0000", instr_out); end
    n_checks++; if (instr_pc !== 16'h0) begin n_fail++; $display("FAIL rst_instr_pc got=%h exp=0000", instr_pc); end
    n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL rst_halted got=%b exp=0", halted); end
    rst = 1'b0;
    step();
    n_checks++; if (mem_rd !== 1'b1) begin n_fail++; $display("FAIL first_req_rd got=%b exp=1", mem_rd); end
    n_checks++; if (mem_addr !== 16'h0000) begin n_fail++; $display("FAIL first_req_addr got=%h exp=0000", mem_addr); end
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL first_req_valid got=%b exp=0", instr_valid); end
    n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL first_req_halted got=%b exp=0", halted); end
  endtask

  task automatic test_single_fetch();
    mem_ack = 1'b1; mem_data = 16'h1234; instr_ready = 1'b1;
    step();
    mem_ack = 1'b0;
    n_checks++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got=%b exp=1", instr_valid); end
    n_checks++; if (instr_out !== 16'h1234) begin n_fail++; $display("FAIL single_out got=%h exp=1234", instr_out); end
    n_checks++; if (instr_pc !== 16'h0000) begin n_fail++; $display("FAIL single_pc got=%h exp=0000", instr_pc); end
    n_checks++; if (mem_rd !== 1'b0) begin n_fail++; $display("FAIL single_hold_rd got=%b exp=0", mem_rd); end
    step();
    n_checks++; if (mem_rd !== 1'b1) begin n_fail++; $display("FAIL single_next_rd got=%b exp=1", mem_rd); end
    n_checks++; if (mem_addr !== 16'h0001) begin n_fail++; $display("FAIL single_next_addr got=%h exp=0001", mem_addr); end
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL single_next_valid got=%b exp=0", instr_valid); end
  endtask

  task automatic test_stall();
    mem_ack = 1'b1; mem_data = 16'hBEEF; instr_ready = 1'b0;
    step();
    mem_ack = 1'b0; mem_data = 16'hFFFF;
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid[%0d] got=%b exp=1", i, instr_valid); end
      n_checks++; if (instr_out !== 16'hBEEF) begin n_fail++; $display("FAIL stall_out[%0d] got=%h exp=beef", i, instr_out); end
      n_checks++; if (instr_pc !== 16'h0001) begin n_fail++; $display("FAIL stall_pc[%0d] got=%h exp=0001", i, instr_pc); end
      n_checks++; if (mem_rd !== 1'b0) begin n_fail++; $display("FAIL stall_rd[%0d] got=%b exp=0", i, mem_rd); end
      step();
    end
    instr_ready = 1'b1;
    step();
    n_checks++; if (mem_rd !== 1'b1) begin n_fail++; $display("FAIL stall_resume_rd got=%b exp=1", mem_rd); end
    n_checks++; if (mem_addr !== 16'h0002) begin n_fail++; $display("FAIL stall_resume_addr got=%h exp=0002", mem_addr); end
  endtask

  task automatic test_redirect();
    mem_ack = 1'b0;
    step();
    step();
    n_checks++; if (mem_rd !== 1'b1 || mem_addr !== 16'h0002) begin n_fail++; $display("FAIL redir_wait got rd=%b addr=%h exp rd=1 addr=0002", mem_rd, mem_addr); end
    // Redirect together with a stale ack: the ack must be dropped.
    redirect = 1'b1; redirect_addr = 16'h0040; mem_ack = 1'b1; mem_data = 16'hDEAD;
    step();
    n_checks++; if (mem_rd !== 1'b0) begin n_fail++; $display("FAIL redir_gap_rd got=%b exp=0", mem_rd); end
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL redir_stale_valid got=%b exp=0", instr_valid); end
    // Late ack for the abandoned request while the bus is idle.
    redirect = 1'b0;
    step();
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL redir_late_valid got=%b exp=0", instr_valid); end
    n_checks++; if (mem_rd !== 1'b1 || mem_addr !== 16'h0040) begin n_fail++; $display("FAIL redir_target got rd=%b addr=%h exp rd=1 addr=0040", mem_rd, mem_addr); end
    mem_data = 16'h0A0A;
    step();
    mem_ack = 1'b0;
    n_checks++; if (instr_valid !== 1'b1 || instr_pc !== 16'h0040 || instr_out !== 16'h0A0A) begin n_fail++; $display("FAIL redir_word got v=%b pc=%h out=%h exp v=1 pc=0040 out=0a0a", instr_valid, instr_pc, instr_out); end
    step();
  endtask

  task automatic test_wrap();
    redirect = 1'b1; redirect_addr = 16'hFFFF;
    step();
    redirect = 1'b0;
    step();
    n_checks++; if (mem_rd !== 1'b1 || mem_addr !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_req got rd=%b addr=%h exp rd=1 addr=ffff", mem_rd, mem_addr); end
    mem_ack = 1'b1; mem_data = 16'h5555;
    step();
    mem_ack = 1'b0;
    n_checks++; if (instr_pc !== 16'hFFFF || instr_out !== 16'h5555) begin n_fail++; $display("FAIL wrap_word got pc=%h out=%h exp pc=ffff out=5555", instr_pc, instr_out); end
    step();
    n_checks++; if (mem_rd !== 1'b1 || mem_addr !== 16'h0000) begin n_fail++; $display("FAIL wrap_next got rd=%b addr=%h exp rd=1 addr=0000", mem_rd, mem_addr); end
  endtask

  task automatic test_halt();
    mem_ack = 1'b1; mem_data = 16'h7777; instr_ready = 1'b0;
    step();
    mem_ack = 1'b0; halt = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (instr_valid !== 1'b1 || instr_out !== 16'h7777) begin n_fail++; $display("FAIL halt_hold[%0d] got v=%b out=%h exp v=1 out=7777", i, instr_valid, instr_out); end
      n_checks++; if (halted !== 1'b0 || mem_rd !== 1'b0) begin n_fail++; $display("FAIL halt_early[%0d] got halted=%b rd=%b exp 0 0", i, halted, mem_rd); end
    end
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    n_checks++; if (halted !== 1'b1 || mem_rd !== 1'b0 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL halt_enter got halted=%b rd=%b v=%b exp 1 0 0", halted, mem_rd, instr_valid); end
    step();
    step();
    n_checks++; if (halted !== 1'b1 || mem_rd !== 1'b0) begin n_fail++; $display("FAIL halt_stay got halted=%b rd=%b exp 1 0", halted, mem_rd); end
    redirect = 1'b1; redirect_addr = 16'h0010; halt = 1'b0;
    step();
    redirect = 1'b0;
    n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL halt_exit got halted=%b exp 0", halted); end
    step();
    n_checks++; if (mem_rd !== 1'b1 || mem_addr !== 16'h0010) begin n_fail++; $display("FAIL halt_resume got rd=%b addr=%h exp rd=1 addr=0010", mem_rd, mem_addr); end
  endtask

  task automatic test_halt_priority();
    // Halt during an outstanding request: the concurrent ack is ignored.
    halt = 1'b1; mem_ack = 1'b1; mem_data = 16'h3333;
    step();
    mem_ack = 1'b0;
    n_checks++; if (halted !== 1'b1 || mem_rd !== 1'b0 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL hreq got halted=%b rd=%b v=%b exp 1 0 0", halted, mem_rd, instr_valid); end
    // Redirect beats halt; halt takes effect one cycle later, no fetch.
    redirect = 1'b1; redirect_addr = 16'h0020;
    step();
    redirect = 1'b0;
    n_checks++; if (halted !== 1'b0 || mem_rd !== 1'b0) begin n_fail++; $display("FAIL hredir got halted=%b rd=%b exp 0 0", halted, mem_rd); end
    step();
    n_checks++; if (halted !== 1'b1 || mem_rd !== 1'b0) begin n_fail++; $display("FAIL hresample got halted=%b rd=%b exp 1 0", halted, mem_rd); end
    redirect = 1'b1; halt = 1'b0;
    step();
    redirect = 1'b0;
    step();
    n_checks++; if (mem_rd !== 1'b1 || mem_addr !== 16'h0020) begin n_fail++; $display("FAIL hrecover got rd=%b addr=%h exp rd=1 addr=0020", mem_rd, mem_addr); end
  endtask

  // Random ready/ack/redirect traffic. The model only tracks which address
  // the next delivered instruction must come from.
  task automatic test_random();
    logic [15:0] exp_pc, prev_out, prev_pc;
    logic        stalled;
    int          n_xfer;
    exp_pc = 16'h0020; stalled = 1'b0; n_xfer = 0; prev_out = '0; prev_pc = '0;
    for (int c = 0; c < 3000; c++) begin
      if (instr_valid) begin
        n_checks++; if (instr_pc !== exp_pc) begin n_fail++; $display("FAIL rnd_pc c=%0d got=%h exp=%h", c, instr_pc, exp_pc); end
        n_checks++; if (instr_out !== ram_word(instr_pc)) begin n_fail++; $display("FAIL rnd_data c=%0d got=%h exp=%h", c, instr_out, ram_word(instr_pc)); end
        if (stalled) begin
          n_checks++; if (instr_out !== prev_out || instr_pc !== prev_pc) begin n_fail++; $display("FAIL rnd_stable c=%0d got=%h@%h exp=%h@%h", c, instr_out, instr_pc, prev_out, prev_pc); end
        end
      end
      if (mem_rd) begin
        n_checks++; if (mem_addr !== exp_pc) begin n_fail++; $display("FAIL rnd_addr c=%0d got=%h exp=%h", c, mem_addr, exp_pc); end
      end
      n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL rnd_halted c=%0d got=%b exp=0", c, halted); end
      instr_ready   = ($urandom_range(0, 2) != 0);
      redirect      = ($urandom_range(0, 19) == 0);
      redirect_addr = 16'($urandom);
      if (mem_rd && $urandom_range(0, 1) == 1) begin
        mem_ack = 1'b1; mem_data = ram_word(mem_addr);
      end else begin
        mem_ack = 1'b0; mem_data = 16'($urandom);
      end
      stalled  = instr_valid && !instr_ready && !redirect;
      prev_out = instr_out;
      prev_pc  = instr_pc;
      if (instr_valid && instr_ready) begin
        exp_pc = exp_pc + 16'd1;
        n_xfer++;
      end
      if (redirect) exp_pc = redirect_addr;
      step();
    end
    redirect = 1'b0; mem_ack = 1'b0; instr_ready = 1'b0;
    n_checks++; if (n_xfer < 300) begin n_fail++; $display("FAIL rnd_throughput got=%0d exp>=300", n_xfer); end
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_stall();
    test_redirect();
    test_wrap();
    test_halt();
    test_halt_priority();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
